// File: rtl/audio_wavegen.sv
// Multi-mode audio waveform generator: phase accumulator drives a step counter
// that is shaped into saw, inverted saw, triangle or variable-duty square samples.
module audio_wavegen #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned FREQ_W   = 16,
  parameter int unsigned ACC_W    = 19
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [FREQ_W-1:0]   freq_i,
  input  logic [1:0]          mode_i,
  input  logic [SAMPLE_W-1:0] duty_i,
  input  logic                en_i,
  input  logic                sync_i,
  output logic [SAMPLE_W-1:0] sample_data_o,
  output logic                sample_tick_o,
  output logic                period_o
);

  typedef enum logic [1:0] {
    MODE_SAW     = 2'd0,
    MODE_INV_SAW = 2'd1,
    MODE_TRI     = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_t;

  if (ACC_W < FREQ_W + 1) begin : g_acc_w_check
    $error("audio_wavegen: ACC_W must be >= FREQ_W+1");
  end

  mode_t               mode;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    inc;
  logic [ACC_W:0]      sum;
  logic [SAMPLE_W:0]   pos;
  logic [SAMPLE_W-1:0] lo;
  logic [SAMPLE_W-1:0] wave;
  logic                step;
  logic                wrap;
  logic                step_q;
  logic                wrap_q;

  always_comb begin
    mode = mode_t'(mode_i);
    lo   = pos[SAMPLE_W-1:0];
    // Triangle walks twice as many steps per period, so it advances at double rate
    inc  = ACC_W'(freq_i);
    if (mode == MODE_TRI) inc = ACC_W'({freq_i, 1'b0});
    sum  = {1'b0, acc} + {1'b0, inc};
    step = en_i & sum[ACC_W];
    wrap = (mode == MODE_TRI) ? (&pos) : (&lo);
    wave = '0;
    unique case (mode)
      MODE_SAW:     wave = lo;
      MODE_INV_SAW: wave = ~lo;
      MODE_TRI:     wave = pos[SAMPLE_W] ? ~lo : lo;
      MODE_SQUARE:  wave = (lo < duty_i) ? '1 : '0;
    endcase
  end

  // Strobes pass through step_q/wrap_q so they line up with the sample they announce
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc           <= '0;
      pos           <= '0;
      step_q        <= 1'b0;
      wrap_q        <= 1'b0;
      sample_data_o <= '0;
      sample_tick_o <= 1'b0;
      period_o      <= 1'b0;
    end else begin
      sample_data_o <= wave;
      sample_tick_o <= step_q;
      period_o      <= wrap_q;
      if (sync_i) begin
        acc    <= '0;
        pos    <= '0;
        step_q <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        step_q <= step;
        wrap_q <= step & wrap;
        if (en_i) acc <= sum[ACC_W-1:0];
        if (step) pos <= pos + (SAMPLE_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_wavegen.sv
// Bench for audio_wavegen: directed scenarios plus random stimulus, all checked
// against a single wide phase counter whose top bits are the waveform position.
module tb_audio_wavegen;

  localparam int unsigned SW = 8;
  localparam int unsigned FW = 16;
  localparam int unsigned AW = 19;
  localparam int unsigned SPAN = 1 << SW;
  localparam longint unsigned PH_MOD = 64'd1 << (SW + 1 + AW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] freq = 16'h8000;
  logic [1:0]    mode = 2'd0;
  logic [SW-1:0] duty = 8'h80;
  logic          en = 1'b1;
  logic          sync = 1'b0;
  logic [SW-1:0] sample;
  logic          tick;
  logic          period;

  int total = 0;
  int bad = 0;
  int ticks = 0;

  longint unsigned phase = 0;
  logic [SW-1:0] exp_sample = '0;
  logic exp_tick = 1'b0, exp_period = 1'b0, pend_step = 1'b0, pend_wrap = 1'b0;

  audio_wavegen #(.SAMPLE_W(SW), .FREQ_W(FW), .ACC_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .freq_i(freq), .mode_i(mode), .duty_i(duty),
    .en_i(en), .sync_i(sync), .sample_data_o(sample), .sample_tick_o(tick),
    .period_o(period)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] ref_wave(int unsigned p, int unsigned m, int unsigned d);
    int unsigned x;
    x = p % SPAN;
    case (m)
      0: return SW'(x);
      1: return SW'(SPAN - 1 - x);
      2: return SW'((p < SPAN) ? p : (2 * SPAN - 1 - p));
      default: return (x < d) ? SW'(SPAN - 1) : SW'(0);
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: advance the reference at the edge, then compare just after it.
  task automatic cyc();
    int unsigned pos_old, pos_new, inc;
    longint unsigned nphase;
    @(posedge clk);
    pos_old = int'(phase >> AW);
    if (rst) begin
      phase = 0; exp_sample = '0; exp_tick = 0; exp_period = 0;
      pend_step = 0; pend_wrap = 0;
    end else begin
      exp_sample = ref_wave(pos_old, mode, duty);
      exp_tick   = pend_step;
      exp_period = pend_wrap;
      if (sync) begin
        phase = 0; pend_step = 0; pend_wrap = 0;
      end else if (en) begin
        inc    = (mode == 2'd2) ? 2 * int'(freq) : int'(freq);
        nphase = (phase + inc) % PH_MOD;
        pos_new = int'(nphase >> AW);
        pend_step = (pos_new != pos_old);
        pend_wrap = pend_step && ((mode == 2'd2) ? (pos_new == 0) : (pos_new % SPAN == 0));
        phase = nphase;
      end else begin
        pend_step = 0; pend_wrap = 0;
      end
    end
    #1;
    check("sample", sample, exp_sample);
    check("tick", tick, exp_tick);
    check("period", period, exp_period);
    if (tick === 1'b1) ticks++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Wait for a period pulse, then count edges/ticks/high ticks up to the next one.
  task automatic measure(output int edges, output int nt, output int nhi);
    int n;
    n = 0; edges = 0; nt = 0; nhi = 0;
    while (period !== 1'b1 && n < 10000) begin cyc(); n++; end
    check("period_seen", period, 1);
    do begin
      cyc(); edges++;
      if (tick === 1'b1) begin
        nt++;
        if (sample == '1) nhi++;
      end
    end while (period !== 1'b1 && edges < 10000);
  endtask

  initial begin
    int n, edges, nt, nhi, t0, cnt;
    logic [SW-1:0] held;

    // Reset during a running saw, then first-step latency
    run(2);
    rst = 0;
    run(40);
    rst = 1;
    run(3);
    check("rst_sample", sample, 0);
    check("rst_tick", tick, 0);
    check("rst_period", period, 0);
    rst = 0;
    n = 0;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < 100);
    check("first_tick_edges", n, 17);

    // Saw and inverted saw period
    measure(edges, nt, nhi);
    check("saw_period_edges", edges, 4096);
    check("saw_period_ticks", nt, 256);
    check("saw_wrap_sample", sample, 8'h00);
    mode = 2'd1;
    run(4);
    measure(edges, nt, nhi);
    check("inv_period_edges", edges, 4096);
    check("inv_wrap_sample", sample, 8'hFF);

    // Triangle, then maximum increment
    mode = 2'd2;
    run(4);
    measure(edges, nt, nhi);
    check("tri_period_edges", edges, 4096);
    check("tri_period_ticks", nt, 512);
    freq = 16'hFFFF;
    run(3000);

    // Saw to square mid-period, then duty measurements
    freq = 16'h8000;
    mode = 2'd0;
    run(1000);
    mode = 2'd3;
    duty = 8'h40;
    run(4);
    measure(edges, nt, nhi);
    check("sq_period_edges", edges, 4096);
    check("sq_high_ticks", nhi, 64);
    check("sq_ticks", nt, 256);
    duty = 8'h00;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      cyc();
      if (i > 1 && sample !== 8'h00) cnt++;
    end
    check("duty0_nonzero", cnt, 0);

    // Sync coincident with a step at output 0x80
    mode = 2'd0;
    n = 0;
    do begin cyc(); n++; end while (!(tick === 1'b1 && sample == 8'h80) && n < 5000);
    check("sync_found_80", sample, 8'h80);
    run(14);
    sync = 1;
    cyc();
    sync = 0;
    cyc();
    check("sync_zero", sample, 8'h00);
    n = 1;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < 100);
    check("sync_first_tick", n, 17);

    // Enable low holds phase
    run(50);
    en = 0;
    run(2);
    held = sample;
    t0 = ticks;
    run(100);
    check("en_hold_sample", sample, held);
    check("en_hold_ticks", ticks - t0, 0);
    en = 1;
    run(300);

    // Zero frequency never steps
    freq = '0;
    run(2);
    t0 = ticks;
    run(10000);
    check("freq0_ticks", ticks - t0, 0);

    // Random segments
    for (int s = 0; s < 25; s++) begin
      freq = ($urandom_range(0, 3) == 0) ? FW'($urandom_range(0, 255))
                                         : FW'($urandom_range(16'h4000, 16'hFFFF));
      mode = 2'($urandom_range(0, 3));
      duty = SW'($urandom_range(0, 255));
      for (int i = 0; i < 300; i++) begin
        en   = ($urandom_range(0, 9) != 0);
        sync = ($urandom_range(0, 99) == 0);
        rst  = ($urandom_range(0, 499) == 0);
        cyc();
      end
      en = 1; sync = 0; rst = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
